// File: rtl/traffic_ctrl_nway_pkg.sv
// Shared state and lamp encodings for the N-way traffic controller.
package traffic_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LIGHT_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_GREEN  = 3'd0,
    ST_YELLOW = 3'd1,
    ST_ALLRED = 3'd2,
    ST_PED    = 3'd3,
    ST_FLASH  = 3'd4
  } state_e;

  typedef enum logic [LIGHT_W-1:0] {
    LT_RED    = 2'b00,
    LT_YELLOW = 2'b01,
    LT_GREEN  = 2'b10,
    LT_OFF    = 2'b11
  } light_e;

endpackage

// File: rtl/traffic_ctrl_nway_if.sv
// Request inputs and lamp/debug outputs of the N-way controller.
interface traffic_ctrl_nway_if
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAY = 4,
  parameter int unsigned SEL_W = 2
);

  logic [N_WAY-1:0]   i_traffic;
  logic               i_mode_p;
  logic               i_mode_r;
  logic [2*N_WAY-1:0] o_light;
  logic               o_walk;
  logic [SEL_W-1:0]   o_sel;
  logic [STATE_W-1:0] o_state;

  modport master (
    output i_traffic, i_mode_p, i_mode_r,
    input  o_light, o_walk, o_sel, o_state
  );

  modport slave (
    input  i_traffic, i_mode_p, i_mode_r,
    output o_light, o_walk, o_sel, o_state
  );

endinterface

// File: rtl/traffic_ctrl_nway_rr_picker.sv
// Round-robin picker: first requesting way after cur, else cur+1 (mod N_WAY).
module rr_picker #(
  parameter int unsigned N_WAY = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_WAY-1:0] req,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next
);

  // Scan cur+1 .. cur+N_WAY, keep the first hit.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    next  = SEL_W'((32'(cur) + 32'd1) % N_WAY);
    for (int unsigned i = 1; i <= N_WAY; i++) begin
      idx = SEL_W'((32'(cur) + i) % N_WAY);
      if (!found && req[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// N-way traffic-light controller: round-robin green, min/max green timing,
// latched pedestrian phase and maintenance flash. Outputs are registered.
module traffic_ctrl_nway
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAY     = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_MIN = 5,
  parameter int unsigned GREEN_MAX = 15,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_T     = 6,
  parameter int unsigned FLASH_T   = 4
) (
  input logic                i_clk,
  input logic                i_rstn,
  traffic_ctrl_nway_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] T_GMIN   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_PED    = CNT_W'(PED_T - 1);
  localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_T - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_WAY - 1);

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [SEL_W-1:0]   sel, sel_d, next_sel;
  logic               ped_pend, ped_d;
  logic               flash_off, flash_off_d;
  logic [2*N_WAY-1:0] light, light_d;
  logic               walk, walk_d;
  logic [N_WAY-1:0]   sel_mask;
  logic               demand;

  rr_picker #(.N_WAY(N_WAY), .SEL_W(SEL_W)) u_rr_picker (
    .req  (bus.i_traffic),
    .cur  (sel),
    .next (next_sel)
  );

  assign sel_mask = N_WAY'(1) << sel;
  assign demand   = (|(bus.i_traffic & ~sel_mask)) | ped_pend;

  // State, timer, arbitration and registered lamp outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_ALLRED;
      cnt       <= '0;
      sel       <= SEL_LAST;
      ped_pend  <= 1'b0;
      flash_off <= 1'b0;
      light     <= '0;
      walk      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sel       <= sel_d;
      ped_pend  <= ped_d;
      flash_off <= flash_off_d;
      light     <= light_d;
      walk      <= walk_d;
    end
  end

  // Next-state logic; lamps are decoded from next state so they align with it.
  always_comb begin
    state_d     = state;
    cnt_d       = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    sel_d       = sel;
    ped_d       = ped_pend;
    flash_off_d = flash_off;
    light_d     = '0;
    walk_d      = 1'b0;

    if (bus.i_mode_p && state != ST_PED && state != ST_FLASH) ped_d = 1'b1;

    case (state)
      ST_GREEN: begin
        if (demand && ((cnt >= T_GMIN && !bus.i_traffic[sel]) || cnt == T_GMAX))
          state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (cnt == T_YELLOW) state_d = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (cnt == T_ALLRED) begin
          if (ped_pend) begin
            state_d = ST_PED;
            // A pulse on this very edge stays pending for the next all-red.
            ped_d   = bus.i_mode_p;
          end else begin
            state_d = ST_GREEN;
            sel_d   = next_sel;
          end
        end
      end
      ST_PED: begin
        if (cnt == T_PED) state_d = ST_ALLRED;
      end
      ST_FLASH: begin
        if (!bus.i_mode_r) begin
          state_d = ST_ALLRED;
        end else if (cnt == T_FLASH) begin
          cnt_d       = '0;
          flash_off_d = ~flash_off;
        end
      end
      default: state_d = ST_ALLRED;
    endcase

    // Maintenance overrides everything; sel parks on the last way so the
    // picker restarts from way 0.
    if (bus.i_mode_r && state != ST_FLASH) begin
      state_d     = ST_FLASH;
      sel_d       = SEL_LAST;
      ped_d       = 1'b0;
      flash_off_d = 1'b0;
    end

    if (state_d != state) cnt_d = '0;

    for (int unsigned k = 0; k < N_WAY; k++) begin
      case (state_d)
        ST_GREEN:  light_d[2*k +: 2] = (SEL_W'(k) == sel_d) ? LT_GREEN  : LT_RED;
        ST_YELLOW: light_d[2*k +: 2] = (SEL_W'(k) == sel_d) ? LT_YELLOW : LT_RED;
        ST_FLASH:  light_d[2*k +: 2] = flash_off_d ? LT_OFF : LT_YELLOW;
        default:   light_d[2*k +: 2] = LT_RED;
      endcase
    end
    walk_d = (state_d == ST_PED);
  end

  assign bus.o_light = light;
  assign bus.o_walk  = walk;
  assign bus.o_sel   = sel;
  assign bus.o_state = state;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench for traffic_ctrl_nway with hand-computed lamp sequences.
module tb_traffic_ctrl_nway;
  import traffic_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  traffic_ctrl_nway_if #(.N_WAY(4), .SEL_W(2)) bus ();

  traffic_ctrl_nway dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // n cycles: advance one edge, then check every output.
  task automatic run(input string tag, input logic [7:0] lt, input logic [1:0] sl,
                     input logic wk, input state_e st, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_light"}, 32'(bus.o_light), 32'(lt));
      chk({tag, "_sel"},   32'(bus.o_sel),   32'(sl));
      chk({tag, "_walk"},  32'(bus.o_walk),  32'(wk));
      chk({tag, "_state"}, 32'(bus.o_state), 32'(st));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.i_traffic = 4'b0100;
    bus.i_mode_p  = 1'b0;
    bus.i_mode_r  = 1'b0;

    // Reset values.
    repeat (10) @(posedge clk);
    #1;
    chk("rst_light", 32'(bus.o_light), 32'h00);
    chk("rst_walk",  32'(bus.o_walk),  32'h0);
    chk("rst_sel",   32'(bus.o_sel),   32'h3);
    chk("rst_state", 32'(bus.o_state), 32'(ST_ALLRED));
    @(negedge clk);
    rst_n = 1'b1;

    // First green on way 2, held with no other demand.
    run("boot_ar", 8'h00, 2'd3, 1'b0, ST_ALLRED, 1);
    run("hold_g2", 8'h20, 2'd2, 1'b0, ST_GREEN, 20);

    // Way 0 request, way 2 gone: immediate yellow, then wrap to way 0.
    bus.i_traffic = 4'b0001;
    run("y2",  8'h10, 2'd2, 1'b0, ST_YELLOW, 3);
    run("ar2", 8'h00, 2'd2, 1'b0, ST_ALLRED, 2);
    run("g0",  8'h02, 2'd0, 1'b0, ST_GREEN, 1);

    // Minimum green: way 1 waits, way 0 leaves -> 5 green cycles.
    bus.i_traffic = 4'b0010;
    run("gmin0", 8'h02, 2'd0, 1'b0, ST_GREEN, 4);
    run("y0",    8'h01, 2'd0, 1'b0, ST_YELLOW, 3);
    run("ar0",   8'h00, 2'd0, 1'b0, ST_ALLRED, 2);
    run("g1",    8'h08, 2'd1, 1'b0, ST_GREEN, 1);

    // Maximum green: both ways keep requesting -> 15 green cycles each.
    bus.i_traffic = 4'b0011;
    run("gmax1", 8'h08, 2'd1, 1'b0, ST_GREEN, 14);
    run("y1",    8'h04, 2'd1, 1'b0, ST_YELLOW, 3);
    run("ar1",   8'h00, 2'd1, 1'b0, ST_ALLRED, 2);
    run("gmax0", 8'h02, 2'd0, 1'b0, ST_GREEN, 15);
    run("y0b",   8'h01, 2'd0, 1'b0, ST_YELLOW, 3);
    run("ar0b",  8'h00, 2'd0, 1'b0, ST_ALLRED, 2);
    run("g1b",   8'h08, 2'd1, 1'b0, ST_GREEN, 1);

    // Pedestrian pulse during green with no traffic.
    bus.i_traffic = 4'b0000;
    bus.i_mode_p  = 1'b1;
    run("pg1",  8'h08, 2'd1, 1'b0, ST_GREEN, 1);
    bus.i_mode_p  = 1'b0;
    run("pg1b", 8'h08, 2'd1, 1'b0, ST_GREEN, 3);
    run("py1",  8'h04, 2'd1, 1'b0, ST_YELLOW, 3);
    run("par1", 8'h00, 2'd1, 1'b0, ST_ALLRED, 2);
    run("ped",  8'h00, 2'd1, 1'b1, ST_PED, 6);
    run("par2", 8'h00, 2'd1, 1'b0, ST_ALLRED, 2);
    run("pg2",  8'h20, 2'd2, 1'b0, ST_GREEN, 1);

    // Maintenance flash, then exit to the lowest requesting way.
    bus.i_mode_r = 1'b1;
    run("fl_on1", 8'h55, 2'd3, 1'b0, ST_FLASH, 4);
    run("fl_off", 8'hFF, 2'd3, 1'b0, ST_FLASH, 4);
    run("fl_on2", 8'h55, 2'd3, 1'b0, ST_FLASH, 4);
    bus.i_mode_r  = 1'b0;
    bus.i_traffic = 4'b1010;
    run("fl_ar", 8'h00, 2'd3, 1'b0, ST_ALLRED, 2);
    run("fl_g1", 8'h08, 2'd1, 1'b0, ST_GREEN, 1);

    // Pedestrian pending, then async reset in yellow drops it.
    bus.i_traffic = 4'b0100;
    bus.i_mode_p  = 1'b1;
    run("rg1",  8'h08, 2'd1, 1'b0, ST_GREEN, 1);
    bus.i_mode_p  = 1'b0;
    run("rg1b", 8'h08, 2'd1, 1'b0, ST_GREEN, 3);
    run("ry1",  8'h04, 2'd1, 1'b0, ST_YELLOW, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_light", 32'(bus.o_light), 32'h00);
    chk("arst_walk",  32'(bus.o_walk),  32'h0);
    chk("arst_sel",   32'(bus.o_sel),   32'h3);
    chk("arst_state", 32'(bus.o_state), 32'(ST_ALLRED));
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("rb_ar", 8'h00, 2'd3, 1'b0, ST_ALLRED, 1);
    run("rb_g2", 8'h20, 2'd2, 1'b0, ST_GREEN, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
